hdp_frame_scheduler: RTL and testbench

//  Sequences pixel packets from the HDMI-side FIFO (FWFT, output clock domain) onto the HDP LCD bus.

---
 rtl/hdp_pkg.sv | 25 ++
 rtl/hdp_phase_counter.sv | 28 ++
 rtl/hdp_frame_scheduler.sv | 129 ++++++++++++
 tb/tb_hdp_frame_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdp_pkg.sv
// Shared definitions for the HDP frame scheduler: state encoding
// and default panel timing.
package hdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_BLANK,
        ST_PORCH
    } state_t;

    localparam int DATA_WIDTH       = 32;
    localparam int PACKETS_PER_LINE = 40;
    localparam int BLANK_PER_LINE   = 4;
    localparam int LINES            = 1280;
    localparam int BACK_PORCH       = 24;
    localparam int UPDATE_PACKETS   = 28;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hdp_phase_counter.sv
// Loadable down counter with terminal-count flag; holds at zero
// until reloaded.
module hdp_phase_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/hdp_frame_scheduler.sv
// Streams FWFT FIFO words onto the HDP LCD bus with line blanking,
// back porch, update window and sticky underrun reporting.
module hdp_frame_scheduler
    import hdp_pkg::*;
#(
    parameter int DATA_WIDTH       = hdp_pkg::DATA_WIDTH,
    parameter int PACKETS_PER_LINE = hdp_pkg::PACKETS_PER_LINE,
    parameter int BLANK_PER_LINE   = hdp_pkg::BLANK_PER_LINE,
    parameter int LINES            = hdp_pkg::LINES,
    parameter int BACK_PORCH       = hdp_pkg::BACK_PORCH,
    parameter int UPDATE_PACKETS   = hdp_pkg::UPDATE_PACKETS
) (
    input  logic                  i_clock,
    input  logic                  i_nReset,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_fifoData,
    input  logic                  i_fifoEmpty,
    output logic                  o_fifoRead,
    output logic [DATA_WIDTH-1:0] o_lcdData,
    output logic                  o_valid,
    output logic                  o_update,
    output logic                  o_frameStart,
    output logic                  o_underrun,
    input  logic                  i_clearUnderrun,
    output logic                  o_busy
);

    localparam int PW = $clog2(max3(PACKETS_PER_LINE, BLANK_PER_LINE, BACK_PORCH) + 1);
    localparam int LW = $clog2(LINES + 1);
    localparam int FL = LINES * (PACKETS_PER_LINE + BLANK_PER_LINE) + BACK_PORCH;
    localparam int FW = $clog2(FL + 1);

    localparam logic [PW-1:0] PPL_V   = PW'(PACKETS_PER_LINE - 1);
    localparam logic [PW-1:0] BLANK_V = PW'(BLANK_PER_LINE - 1);
    localparam logic [PW-1:0] PORCH_V = PW'(BACK_PORCH - 1);
    localparam logic [LW-1:0] LINES_V = LW'(LINES - 1);

    state_t        state;
    logic [FW-1:0] frame_cycle;
    logic [PW-1:0] phase_value;
    logic          phase_load;
    logic          phase_done;
    logic          line_load;
    logic          line_en;
    logic          line_done;
    logic          data_slot;

    assign data_slot  = (state == ST_DATA);
    assign o_busy     = (state != ST_IDLE);
    // Gated by reset so an aborted line never drops a word from the FIFO.
    assign o_fifoRead = i_nReset && data_slot && !i_fifoEmpty;

    assign phase_load = (state == ST_IDLE) || phase_done;
    assign line_load  = (state == ST_IDLE) || (state == ST_PORCH && phase_done);
    assign line_en    = (state == ST_BLANK) && phase_done;

    always_comb begin
        phase_value = PPL_V;
        unique case (state)
            ST_DATA:  phase_value = BLANK_V;
            ST_BLANK: phase_value = line_done ? PORCH_V : PPL_V;
            default:  phase_value = PPL_V;
        endcase
    end

    hdp_phase_counter #(.WIDTH(PW)) u_phase (
        .clock   (i_clock),
        .reset_n (i_nReset),
        .load    (phase_load),
        .enable  (1'b1),
        .value   (phase_value),
        .done    (phase_done)
    );

    hdp_phase_counter #(.WIDTH(LW)) u_line (
        .clock   (i_clock),
        .reset_n (i_nReset),
        .load    (line_load),
        .enable  (line_en),
        .value   (LINES_V),
        .done    (line_done)
    );

    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            state        <= ST_IDLE;
            frame_cycle  <= '0;
            o_lcdData    <= '0;
            o_valid      <= 1'b0;
            o_update     <= 1'b0;
            o_frameStart <= 1'b0;
            o_underrun   <= 1'b0;
        end else begin
            o_valid      <= data_slot;
            o_lcdData    <= (data_slot && !i_fifoEmpty) ? i_fifoData : '0;
            o_update     <= o_busy && (int'(frame_cycle) < UPDATE_PACKETS);
            o_frameStart <= data_slot && (frame_cycle == '0);
            if (data_slot && i_fifoEmpty) begin
                o_underrun <= 1'b1;
            end else if (i_clearUnderrun) begin
                o_underrun <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    frame_cycle <= '0;
                    if (i_enable && !i_fifoEmpty) state <= ST_DATA;
                end
                ST_DATA: begin
                    frame_cycle <= frame_cycle + FW'(1);
                    if (phase_done) state <= ST_BLANK;
                end
                ST_BLANK: begin
                    frame_cycle <= frame_cycle + FW'(1);
                    if (phase_done) state <= line_done ? ST_PORCH : ST_DATA;
                end
                ST_PORCH: begin
                    if (phase_done) begin
                        frame_cycle <= '0;
                        state       <= i_enable ? ST_DATA : ST_IDLE;
                    end else begin
                        frame_cycle <= frame_cycle + FW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdp_frame_scheduler.sv
// Bench for hdp_frame_scheduler with a frame-position reference model
// and a queue standing in for the FWFT FIFO.
module tb_hdp_frame_scheduler;

    localparam int DW  = 32;
    localparam int PPL = 4;
    localparam int BL  = 2;
    localparam int LN  = 2;
    localparam int PR  = 3;
    localparam int UPD = 5;
    localparam int LL  = PPL + BL;
    localparam int FL  = LN * LL + PR;

    logic          clk;
    logic          nreset;
    logic          en;
    logic          clr;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          o_fifoRead;
    logic [DW-1:0] o_lcdData;
    logic          o_valid;
    logic          o_update;
    logic          o_frameStart;
    logic          o_underrun;
    logic          o_busy;

    hdp_frame_scheduler #(
        .DATA_WIDTH       (DW),
        .PACKETS_PER_LINE (PPL),
        .BLANK_PER_LINE   (BL),
        .LINES            (LN),
        .BACK_PORCH       (PR),
        .UPDATE_PACKETS   (UPD)
    ) dut (
        .i_clock         (clk),
        .i_nReset        (nreset),
        .i_enable        (en),
        .i_fifoData      (fifo_data),
        .i_fifoEmpty     (fifo_empty),
        .o_fifoRead      (o_fifoRead),
        .o_lcdData       (o_lcdData),
        .o_valid         (o_valid),
        .o_update        (o_update),
        .o_frameStart    (o_frameStart),
        .o_underrun      (o_underrun),
        .i_clearUnderrun (clr),
        .o_busy          (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    int            n_cmp;
    int            n_bad;
    int            cyc;

    // Reference model: frame position rather than FSM state.
    bit            m_run;
    int            m_pos;
    bit            m_ur;

    logic          obs_read, obs_busy, e_read, e_busy;
    logic          e_valid, e_update, e_fs;
    logic [DW-1:0] e_data;
    logic [37:0]   obs_vec, exp_vec;

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_data  = fifo_empty ? $urandom : q[0];
    endtask

    task automatic push(input logic [DW-1:0] w);
        q.push_back(w);
        refresh();
    endtask

    task automatic tick();
        bit            slot, emp, rd;
        logic [DW-1:0] head;
        refresh();
        @(negedge clk);
        emp  = (q.size() == 0);
        head = emp ? '0 : q[0];
        slot = m_run && (m_pos < LN * LL) && ((m_pos % LL) < PPL);
        rd   = nreset && slot && !emp;
        obs_read = o_fifoRead;
        obs_busy = o_busy;
        e_read   = rd;
        e_busy   = m_run;
        @(posedge clk);
        if (rd) void'(q.pop_front());
        if (!nreset) begin
            e_valid = 0; e_update = 0; e_fs = 0; e_data = '0;
            m_ur = 0; m_run = 0; m_pos = 0;
        end else begin
            e_valid  = slot;
            e_data   = rd ? head : '0;
            e_update = m_run && (m_pos < UPD);
            e_fs     = m_run && (m_pos == 0);
            if (slot && emp) m_ur = 1;
            else if (clr) m_ur = 0;
            if (!m_run) begin
                if (en && !emp) begin m_run = 1; m_pos = 0; end
            end else begin
                m_pos++;
                if (m_pos == FL) begin m_pos = 0; m_run = en; end
            end
        end
        #1;
        cyc++;
        refresh();
        obs_vec = {obs_read, obs_busy, o_valid, o_update, o_frameStart, o_underrun, o_lcdData};
        exp_vec = {e_read, e_busy, e_valid, e_update, e_fs, m_ur, e_data};
    endtask

    task automatic test_reset();
        nreset = 0; en = 1; clr = 0;
        q.delete();
        push(32'h5); push(32'h6);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL reset cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (q.size() !== 2) begin
            n_bad++;
            $display("FAIL reset_nopop: got %0d words want 2", q.size());
        end
    endtask

    task automatic test_full_frame();
        logic [14:0] vb;
        logic [DW-1:0] got[$];
        int nfs, nupd;
        vb = '0; nfs = 0; nupd = 0;
        nreset = 0; tick();
        q.delete();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        nreset = 1; en = 1; clr = 0;
        for (int t = 1; t <= 18; t++) begin
            if (t == 5) en = 0;
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL full_frame cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            if (t >= 2 && t <= 16) vb = {vb[13:0], o_valid};
            if (o_valid) got.push_back(o_lcdData);
            if (o_frameStart) nfs++;
            if (o_update) nupd++;
        end
        n_cmp++;
        if (vb !== 15'b111100111100000) begin
            n_bad++;
            $display("FAIL full_valid_pattern: got %b want 111100111100000", vb);
        end
        n_cmp++;
        if (got.size() != 8 || got[0] !== 1 || got[3] !== 4 || got[7] !== 8) begin
            n_bad++;
            $display("FAIL full_data_order: got %0d words want 1..8", got.size());
        end
        n_cmp++;
        if (nfs != 1 || nupd != 5) begin
            n_bad++;
            $display("FAIL full_pulses: got fs=%0d upd=%0d want 1 5", nfs, nupd);
        end
    endtask

    task automatic test_underrun();
        logic [14:0] vb;
        vb = '0;
        nreset = 0; tick();
        q.delete();
        for (int i = 0; i < 3; i++) push($urandom | 32'h1);
        nreset = 1; en = 1; clr = 0;
        for (int t = 1; t <= 18; t++) begin
            if (t == 5) en = 0;
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL underrun cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            if (t == 5) begin
                n_cmp++;
                if ({o_valid, o_lcdData, o_underrun} !== {1'b1, 32'h0, 1'b1}) begin
                    n_bad++;
                    $display("FAIL underrun_pkt4: got v=%b d=%h u=%b want 1 0 1",
                             o_valid, o_lcdData, o_underrun);
                end
            end
            if (t >= 2 && t <= 16) vb = {vb[13:0], o_valid};
        end
        n_cmp++;
        if (vb !== 15'b111100111100000 || o_underrun !== 1'b1) begin
            n_bad++;
            $display("FAIL underrun_timing: got %b u=%b want 111100111100000 1", vb, o_underrun);
        end
    endtask

    task automatic test_clear_vs_set();
        nreset = 0; tick();
        q.delete();
        for (int i = 0; i < 3; i++) push($urandom);
        nreset = 1; en = 1; clr = 0;
        for (int t = 1; t <= 18; t++) begin
            clr = (t == 5) || (t == 6);
            if (t == 6) for (int i = 0; i < 4; i++) push($urandom);
            if (t == 7) en = 0;
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL clear_set cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            if (t == 5 || t == 6) begin
                n_cmp++;
                if (o_underrun !== (t == 5)) begin
                    n_bad++;
                    $display("FAIL clear_set_t%0d: got %b want %b", t, o_underrun, t == 5);
                end
            end
        end
        clr = 0;
    endtask

    task automatic test_disable_mid_frame();
        int fall;
        fall = -1;
        nreset = 0; tick();
        q.delete();
        for (int i = 0; i < 10; i++) push($urandom);
        nreset = 1; en = 1; clr = 0;
        for (int t = 1; t <= 20; t++) begin
            if (t == 8) en = 0;
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL disable cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            if (t > 2 && fall < 0 && !obs_busy) fall = t - 2;
        end
        n_cmp++;
        if (fall != 15 || q.size() != 2) begin
            n_bad++;
            $display("FAIL disable_end: got fall=%0d left=%0d want 15 2", fall, q.size());
        end
    endtask

    task automatic test_back_to_back();
        int fs[$];
        nreset = 0; tick();
        q.delete();
        for (int i = 0; i < 20; i++) push($urandom);
        nreset = 1; en = 1; clr = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL b2b cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            if (o_frameStart) fs.push_back(t);
        end
        n_cmp++;
        if (fs.size() != 2 || fs[1] - fs[0] != 15) begin
            n_bad++;
            $display("FAIL b2b_period: got %0d starts want 2 spaced 15", fs.size());
        end
        nreset = 0;
        tick();
        n_cmp++;
        if ({o_valid, o_update, o_frameStart, o_underrun, o_lcdData} !== '0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_reset: got v=%b d=%h busy=%b want all 0", o_valid, o_lcdData, o_busy);
        end
        nreset = 1; q.delete();
        for (int t = 0; t < 6; t++) begin
            if (t == 3) push($urandom);
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL restart cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            if (t == 2) begin
                n_cmp++;
                if (o_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL restart_wait: got busy=%b want 0", o_busy);
                end
            end
        end
    endtask

    task automatic test_random();
        nreset = 0; tick();
        q.delete();
        nreset = 1; en = 1;
        for (int t = 0; t < 600; t++) begin
            en     = ($urandom_range(0, 19) != 0);
            clr    = ($urandom_range(0, 7) == 0);
            nreset = ($urandom_range(0, 149) != 0);
            if (q.size() < 12 && $urandom_range(0, 9) < 7) push($urandom);
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        nreset = 1; clr = 0; en = 0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        m_run = 0; m_pos = 0; m_ur = 0;
        nreset = 0; en = 0; clr = 0;
        refresh();
        test_reset();
        test_full_frame();
        test_underrun();
        test_clear_vs_set();
        test_disable_mid_frame();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
